eth_rxdecap: RTL and testbench

RX-side counterpart of the TX encapsulation stage. It consumes the 10G MAC receive AXI-Stream in the clk156 domain and validates the Ethernet header (EtherType, optionally destination MAC). It strips the 14-byte header, realigns the payload to byte 0 and writes 74-bit words into the eth2pcie FIFO. This is the same word format the TX path carries.

---
 rtl/eth_rxdecap_if.sv | 22 ++
 rtl/eth_rxdecap.sv | 186 ++++++++++++++++++
 tb/tb_eth_rxdecap.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_rxdecap_if.sv
// MAC receive stream and eth2pcie FIFO write port of the RX decapsulator.
interface eth_rxdecap_if;
    logic        s_axis_rx_tvalid;
    logic [63:0] s_axis_rx_tdata;
    logic [7:0]  s_axis_rx_tkeep;
    logic        s_axis_rx_tlast;
    logic        s_axis_rx_tuser;
    logic        wr_en;
    logic [73:0] din;
    logic        full;

    modport slave (
        input  s_axis_rx_tvalid, s_axis_rx_tdata, s_axis_rx_tkeep, s_axis_rx_tlast,
        input  s_axis_rx_tuser, full,
        output wr_en, din
    );
    modport master (
        output s_axis_rx_tvalid, s_axis_rx_tdata, s_axis_rx_tkeep, s_axis_rx_tlast,
        output s_axis_rx_tuser, full,
        input  wr_en, din
    );
endinterface

// File: rtl/eth_rxdecap.sv
// Ethernet RX decap: header check/strip, payload realigned to byte 0, 74-bit eth2pcie FIFO words.
// Destination-MAC filter compiled in with `define DECAP_MACFILT_EN.
module eth_rxdecap #(
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter logic [47:0] LOCAL_MAC = 48'h00_11_22_33_44_55,
    parameter int          CNT_W     = 32
) (
    input  logic             clk156,
    input  logic             sys_rst_n,
    eth_rxdecap_if.slave     rx,
    output logic [CNT_W-1:0] cnt_good,
    output logic [CNT_W-1:0] cnt_drop,
    output logic [CNT_W-1:0] cnt_err
);
    typedef enum logic [2:0] {S_SYNC, S_HDR0, S_HDR1, S_DATA, S_FLUSH, S_DROP} state_t;

    state_t           state_q, state_d;
    logic [15:0]      resid_q, resid_d;
    logic [1:0]       fl_n_q, fl_n_d;
    logic             fl_user_q, fl_user_d;
    logic             dst_ok_q, dst_ok_d;
    logic             term_q, term_d;
    logic             wr_q, wr_d;
    logic [73:0]      din_q, din_d;
    logic [CNT_W-1:0] good_q, good_d, drop_q, drop_d, err_q, err_d;

    logic        vld, last, dst_hit, wr_need, ovf, do_hdr0;
    logic [63:0] dat;
    logic [3:0]  nkeep;
    logic [15:0] etype;
    logic [73:0] word;

    function automatic logic [3:0] popc(input logic [7:0] k);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, k[i]};
        return n;
    endfunction

    function automatic logic [7:0] keep_mask(input logic [3:0] n);
        logic [8:0] m;
        m = (9'd1 << n) - 9'd1;
        return m[7:0];
    endfunction

    assign vld   = rx.s_axis_rx_tvalid;
    assign last  = rx.s_axis_rx_tlast;
    assign dat   = rx.s_axis_rx_tdata;
    assign nkeep = popc(rx.s_axis_rx_tkeep);
    assign etype = {dat[39:32], dat[47:40]};

`ifdef DECAP_MACFILT_EN
    logic [47:0] dst_mac;
    assign dst_mac = {dat[7:0], dat[15:8], dat[23:16], dat[31:24], dat[39:32], dat[47:40]};
    assign dst_hit = (dst_mac == LOCAL_MAC) || (dst_mac == 48'hFFFF_FFFF_FFFF);
`else
    logic unused_mac;
    assign unused_mac = ^LOCAL_MAC;
    assign dst_hit    = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        resid_d   = resid_q;
        fl_n_d    = fl_n_q;
        fl_user_d = fl_user_q;
        dst_ok_d  = dst_ok_q;
        term_d    = term_q;
        wr_d      = 1'b0;
        din_d     = din_q;
        good_d    = good_q;
        drop_d    = drop_q;
        err_d     = err_q;
        wr_need   = 1'b0;
        word      = '0;
        do_hdr0   = 1'b0;

        case (state_q)
            S_SYNC:  if (!vld || last) state_d = S_HDR0;
            S_HDR0:  do_hdr0 = 1'b1;
            S_HDR1: if (vld) begin
                if (etype != ETHERTYPE || !dst_ok_q || (last && nkeep <= 4'd6)) begin
                    drop_d  = drop_q + CNT_W'(1);
                    state_d = last ? S_HDR0 : S_DROP;
                end else begin
                    resid_d = dat[63:48];
                    if (last) begin
                        fl_n_d    = 2'(nkeep - 4'd6);
                        fl_user_d = ~rx.s_axis_rx_tuser;
                        state_d   = S_FLUSH;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: if (vld) begin
                // previous beat's bytes 6,7 lead the output word
                wr_need = 1'b1;
                resid_d = dat[63:48];
                word    = {2'b00, 8'hFF, dat[47:0], resid_q};
                if (last) begin
                    if (nkeep <= 4'd6) begin
                        word[73:64] = {~rx.s_axis_rx_tuser, 1'b1, keep_mask(nkeep + 4'd2)};
                        state_d     = S_HDR0;
                    end else begin
                        fl_n_d    = 2'(nkeep - 4'd6);
                        fl_user_d = ~rx.s_axis_rx_tuser;
                        state_d   = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                wr_need = 1'b1;
                word    = {fl_user_q, 1'b1, keep_mask({2'b00, fl_n_q}), 48'h0, resid_q};
                state_d = S_HDR0;
                do_hdr0 = 1'b1;
            end
            S_DROP:  if (vld && last) state_d = S_HDR0;
            default: state_d = S_SYNC;
        endcase

        ovf = wr_need & rx.full;

        // a frame starting while a terminator is owed (or becomes owed now) is dropped whole
        if (do_hdr0 && vld) begin
            dst_ok_d = dst_hit;
            if (term_q || ovf || last) begin
                drop_d  = drop_q + CNT_W'(1);
                state_d = last ? S_HDR0 : S_DROP;
            end else begin
                state_d = S_HDR1;
            end
        end

        if (ovf) begin
            term_d = 1'b1;
            err_d  = err_q + CNT_W'(1);
            if (state_q == S_DATA) state_d = last ? S_HDR0 : S_DROP;
        end else if (wr_need) begin
            wr_d  = 1'b1;
            din_d = word;
            if (word[72]) begin
                if (word[73]) err_d  = err_q + CNT_W'(1);
                else          good_d = good_q + CNT_W'(1);
            end
        end else if (term_q && !rx.full) begin
            wr_d   = 1'b1;
            din_d  = {2'b11, 72'h0};
            term_d = 1'b0;
        end
    end

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_SYNC;
            resid_q   <= '0;
            fl_n_q    <= '0;
            fl_user_q <= 1'b0;
            dst_ok_q  <= 1'b0;
            term_q    <= 1'b0;
            wr_q      <= 1'b0;
            din_q     <= '0;
            good_q    <= '0;
            drop_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            resid_q   <= resid_d;
            fl_n_q    <= fl_n_d;
            fl_user_q <= fl_user_d;
            dst_ok_q  <= dst_ok_d;
            term_q    <= term_d;
            wr_q      <= wr_d;
            din_q     <= din_d;
            good_q    <= good_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
        end
    end

    assign rx.wr_en = wr_q;
    assign rx.din   = din_q;
    assign cnt_good = good_q;
    assign cnt_drop = drop_q;
    assign cnt_err  = err_q;
endmodule

// File: tb/tb_eth_rxdecap.sv
// Bench for eth_rxdecap: directed frame table, overflow and reset sequences, random frames
// compared against a payload-level model of the decapsulated stream.
module tb_eth_rxdecap;
    localparam logic [15:0] ETYPE = 16'h88B5;
    localparam logic [47:0] LMAC  = 48'h00_11_22_33_44_55;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] OMAC  = 48'h02_00_00_00_00_01;
    localparam logic [73:0] TERM  = {2'b11, 72'h0};
`ifdef DECAP_MACFILT_EN
    localparam bit MF = 1'b1;
`else
    localparam bit MF = 1'b0;
`endif

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [73:0] word_q_t[$];
    typedef struct {
        int          len;
        logic [47:0] dst;
        logic [15:0] et;
        bit          fcs;
        int          nwr;
        logic [7:0]  lkeep;
        bit          luser;
    } vec_t;

    logic        clk156 = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [31:0] cnt_good, cnt_drop, cnt_err;
    int          errors = 0, checks = 0;
    int          exp_good = 0, exp_drop = 0, exp_err = 0;
    word_q_t     got;
    vec_t        tbl[15];

    eth_rxdecap_if rxif();
    eth_rxdecap dut (
        .clk156(clk156), .sys_rst_n(sys_rst_n), .rx(rxif),
        .cnt_good(cnt_good), .cnt_drop(cnt_drop), .cnt_err(cnt_err)
    );

    always #5 clk156 = ~clk156;
    always @(negedge clk156) if (rxif.wr_en === 1'b1) got.push_back(rxif.din);

    task automatic chk(input string nm, input logic [73:0] act, input logic [73:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cmp_q(input string nm, input word_q_t e);
        chk({nm, " count"}, 74'(got.size()), 74'(e.size()));
        for (int i = 0; i < e.size() && i < got.size(); i++)
            chk($sformatf("%s word%0d", nm, i), got[i], e[i]);
    endtask

    task automatic chk_cnt(input string nm);
        chk({nm, " cnt_good"}, 74'(cnt_good), 74'(exp_good));
        chk({nm, " cnt_drop"}, 74'(cnt_drop), 74'(exp_drop));
        chk({nm, " cnt_err"},  74'(cnt_err),  74'(exp_err));
    endtask

    function automatic byte_q_t mk_frame(input int len, input logic [47:0] dst, input logic [15:0] et);
        byte_q_t     f;
        logic [111:0] hdr;
        hdr = {dst, 48'h66_77_88_99_AA_BB, et};
        for (int i = 0; i < len; i++)
            f.push_back(i < 14 ? hdr[111-8*i -: 8] : 8'($urandom));
        return f;
    endfunction

    // Frame-level rules: accept when longer than the header with the right EtherType (and dst),
    // then chop the payload into 8-byte words; FCS status lands on the last word.
    task automatic model(input byte_q_t f, input bit fcs, inout word_q_t q, output int kind);
        int          n, p;
        bit          ok;
        logic [47:0] dst;
        logic [73:0] wd;
        n  = f.size();
        ok = (n > 14);
        if (ok) ok = ({f[12], f[13]} == ETYPE);
        dst = '0;
        if (ok) dst = {f[0], f[1], f[2], f[3], f[4], f[5]};
        if (ok && MF) ok = (dst == LMAC) || (dst == BCAST);
        kind = 2;
        if (ok) begin
            p = n - 14;
            for (int w = 0; w * 8 < p; w++) begin
                wd = '0;
                for (int k = 0; k < 8; k++)
                    if (w * 8 + k < p) begin
                        wd[8*k +: 8] = f[14 + w*8 + k];
                        wd[64 + k]   = 1'b1;
                    end
                wd[72] = (w * 8 + 8 >= p);
                wd[73] = (w * 8 + 8 >= p) && !fcs;
                q.push_back(wd);
            end
            kind = fcs ? 0 : 1;
        end
    endtask

    task automatic account(input int kind);
        case (kind)
            0: exp_good++;
            1: exp_err++;
            default: exp_drop++;
        endcase
    endtask

    task automatic drive_beat(input byte_q_t f, input int b, input bit fcs, input bit fl);
        int n;
        n = f.size();
        @(negedge clk156);
        rxif.s_axis_rx_tdata = '0;
        rxif.s_axis_rx_tkeep = '0;
        for (int k = 0; k < 8; k++)
            if (b * 8 + k < n) begin
                rxif.s_axis_rx_tdata[8*k +: 8] = f[b*8 + k];
                rxif.s_axis_rx_tkeep[k]        = 1'b1;
            end
        rxif.s_axis_rx_tvalid = 1'b1;
        rxif.s_axis_rx_tlast  = (b * 8 + 8 >= n);
        rxif.s_axis_rx_tuser  = (b * 8 + 8 >= n) && fcs;
        rxif.full             = fl;
    endtask

    task automatic send_frame(input byte_q_t f, input bit fcs, input logic [15:0] fullm);
        for (int b = 0; b * 8 < f.size(); b++) drive_beat(f, b, fcs, fullm[b]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk156);
            rxif.s_axis_rx_tvalid = 1'b0;
            rxif.s_axis_rx_tlast  = 1'b0;
            rxif.s_axis_rx_tuser  = 1'b0;
            rxif.full             = 1'b0;
        end
    endtask

    initial begin
        byte_q_t     f, f2;
        word_q_t     e, e2;
        int          k;
        logic [73:0] lw;

        tbl[0]  = '{78, LMAC,  ETYPE,    1'b1, 8,       8'hFF, 1'b0};
        tbl[1]  = '{17, LMAC,  ETYPE,    1'b1, 1,       8'h07, 1'b0};
        tbl[2]  = '{23, LMAC,  ETYPE,    1'b1, 2,       8'h01, 1'b0};
        tbl[3]  = '{78, LMAC,  16'h0800, 1'b1, 0,       8'h00, 1'b0};
        tbl[4]  = '{30, LMAC,  ETYPE,    1'b0, 2,       8'hFF, 1'b1};
        tbl[5]  = '{14, LMAC,  ETYPE,    1'b1, 0,       8'h00, 1'b0};
        tbl[6]  = '{5,  LMAC,  ETYPE,    1'b1, 0,       8'h00, 1'b0};
        tbl[7]  = '{15, LMAC,  ETYPE,    1'b1, 1,       8'h01, 1'b0};
        tbl[8]  = '{16, LMAC,  ETYPE,    1'b1, 1,       8'h03, 1'b0};
        tbl[9]  = '{21, LMAC,  ETYPE,    1'b1, 1,       8'h7F, 1'b0};
        tbl[10] = '{22, LMAC,  ETYPE,    1'b1, 1,       8'hFF, 1'b0};
        tbl[11] = '{24, LMAC,  ETYPE,    1'b0, 2,       8'h03, 1'b1};
        tbl[12] = '{20, OMAC,  ETYPE,    1'b1, MF ? 0 : 1, 8'h3F, 1'b0};
        tbl[13] = '{20, BCAST, ETYPE,    1'b1, 1,       8'h3F, 1'b0};
        tbl[14] = '{13, LMAC,  ETYPE,    1'b1, 0,       8'h00, 1'b0};

        rxif.s_axis_rx_tvalid = 1'b0;
        rxif.s_axis_rx_tdata  = '0;
        rxif.s_axis_rx_tkeep  = '0;
        rxif.s_axis_rx_tlast  = 1'b0;
        rxif.s_axis_rx_tuser  = 1'b0;
        rxif.full             = 1'b0;
        repeat (3) @(negedge clk156);
        chk("reset wr_en", 74'(rxif.wr_en), 74'(0));
        chk("reset din", rxif.din, 74'(0));
        chk_cnt("reset");
        sys_rst_n = 1'b1;
        idle(3);

        for (int i = 0; i < 15; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            f  = mk_frame(tbl[i].len, tbl[i].dst, tbl[i].et);
            e  = {};
            model(f, tbl[i].fcs, e, k);
            account(k);
            got = {};
            send_frame(f, tbl[i].fcs, 16'h0);
            idle(4);
            chk({nm, " nwr"}, 74'(got.size()), 74'(tbl[i].nwr));
            cmp_q(nm, e);
            if (tbl[i].nwr > 0 && got.size() > 0) begin
                lw = got[got.size() - 1];
                chk({nm, " last keep"}, 74'(lw[71:64]), 74'(tbl[i].lkeep));
                chk({nm, " last user/tlast"}, 74'(lw[73:72]), 74'({tbl[i].luser, 1'b1}));
            end
        end
        chk_cnt("table");

        // bad EtherType frame immediately followed by a good one
        f  = mk_frame(40, LMAC, 16'h0800);
        f2 = mk_frame(40, LMAC, ETYPE);
        e  = {};
        model(f, 1'b1, e, k);  account(k);
        model(f2, 1'b1, e, k); account(k);
        got = {};
        send_frame(f, 1'b1, 16'h0);
        send_frame(f2, 1'b1, 16'h0);
        idle(4);
        cmp_q("b2b", e);
        chk_cnt("b2b");

        // full over beats 4,5 of A and beat 0 of B: A truncated, B dropped, one terminator
        f  = mk_frame(48, LMAC, ETYPE);
        f2 = mk_frame(30, LMAC, ETYPE);
        e  = {};
        model(f, 1'b1, e, k);
        e2 = {e[0], e[1], TERM};
        exp_err++;
        exp_drop++;
        got = {};
        send_frame(f, 1'b1, 16'b11_0000);
        send_frame(f2, 1'b1, 16'b1);
        idle(4);
        cmp_q("ovf", e2);
        chk_cnt("ovf");

        f = mk_frame(50, LMAC, ETYPE);
        e = {};
        model(f, 1'b1, e, k); account(k);
        got = {};
        send_frame(f, 1'b1, 16'h0);
        idle(4);
        cmp_q("ovf recover", e);
        chk_cnt("ovf recover");

        // reset pulse in the middle of a frame; the tail must be ignored
        f = mk_frame(78, LMAC, ETYPE);
        for (int b = 0; b < 10; b++) begin
            drive_beat(f, b, 1'b1, 1'b0);
            if (b == 4) begin
                sys_rst_n = 1'b0;
                #1;
                chk("mid-rst wr_en", 74'(rxif.wr_en), 74'(0));
                exp_good = 0; exp_drop = 0; exp_err = 0;
                chk_cnt("mid-rst");
            end
            if (b == 5) sys_rst_n = 1'b1;
        end
        idle(2);
        got = {};
        f = mk_frame(40, LMAC, ETYPE);
        e = {};
        model(f, 1'b1, e, k); account(k);
        send_frame(f, 1'b1, 16'h0);
        idle(4);
        cmp_q("post-rst", e);
        chk_cnt("post-rst");

        // random frames, gaps of 0..2 idle cycles
        e   = {};
        got = {};
        for (int i = 0; i < 40; i++) begin
            int          len;
            logic [47:0] dst;
            logic [15:0] et;
            bit          fcs;
            len = $urandom_range(1, 100);
            case ($urandom_range(0, 2))
                0:       dst = LMAC;
                1:       dst = BCAST;
                default: dst = OMAC;
            endcase
            et  = ($urandom_range(0, 3) != 0) ? ETYPE : 16'($urandom);
            fcs = ($urandom_range(0, 5) != 0);
            f   = mk_frame(len, dst, et);
            model(f, fcs, e, k);
            account(k);
            send_frame(f, fcs, 16'h0);
            idle($urandom_range(0, 2));
        end
        idle(5);
        cmp_q("rand", e);
        chk_cnt("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
